// File: rtl/serial_adder_arbiter_pkg.sv
// Shared types and sizing helpers for the serial adder arbiter.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DONE_S = 2'd2
  } state_t;

  localparam int SIZE_DEF    = 8;
  localparam int ADD_LAT_DEF = 10;

  // Run counter only needs to reach lat-1; keep at least one bit for lat == 1.
  function automatic int cnt_width(input int lat);
    return (lat > 1) ? $clog2(lat) : 1;
  endfunction

  localparam int CNT_W_DEF = cnt_width(ADD_LAT_DEF);

endpackage

// File: rtl/serial_adder_arbiter_rr_pick.sv
// Round-robin pick: first set request bit at or after the pointer, wrapping modulo NREQ.
module rr_pick
  import serial_adder_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [NREQ-1:0]  o_onehot,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  logic [NREQ-1:0] w_rot;

  // Rotate so bit 0 is the requester the pointer names.
  assign w_rot = (i_req >> i_ptr) | (i_req << (NREQ - int'(i_ptr)));

  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!o_any && w_rot[k]) begin
        o_any    = 1'b1;
        o_idx    = IDX_W'((int'(i_ptr) + k) % NREQ);
        o_onehot = NREQ'(1) << o_idx;
      end
    end
  end

endmodule

// File: rtl/serial_adder_arbiter.sv
// Shares one serial adder between NREQ requesters: grant, hold START for ADD_LAT cycles,
// capture SUM with a DONE pulse, then leave a START-low gap so the adder re-arms.
module serial_adder_arbiter
  import serial_adder_pkg::*;
#(
  parameter int SIZE    = SIZE_DEF,
  parameter int NREQ    = 4,
  parameter int ADD_LAT = ADD_LAT_DEF
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NREQ-1:0]      REQ,
  input  logic [NREQ*SIZE-1:0] A_IN,
  input  logic [NREQ*SIZE-1:0] B_IN,
  output logic [NREQ-1:0]      GNT,
  output logic [NREQ-1:0]      DONE,
  output logic [SIZE:0]        SUM_OUT,
  output logic                 BUSY,
  output logic                 ADD_START,
  output logic [SIZE-1:0]      ADD_A,
  output logic [SIZE-1:0]      ADD_B,
  input  logic [SIZE:0]        ADD_SUM
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int CNT_W = cnt_width(ADD_LAT);

  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_ptr, r_w;
  logic [NREQ-1:0]  r_gnt, r_done;
  logic [SIZE:0]    r_sum;
  logic             r_busy, r_start;
  logic [SIZE-1:0]  r_add_a, r_add_b;

  logic [NREQ-1:0]  w_onehot;
  logic [IDX_W-1:0] w_idx;
  logic             w_any;
  logic             w_last;

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .i_req    (REQ),
    .i_ptr    (r_ptr),
    .o_onehot (w_onehot),
    .o_idx    (w_idx),
    .o_any    (w_any)
  );

  always_comb begin
    w_next = r_state;
    w_last = (r_cnt == CNT_W'(ADD_LAT - 1));
    case (r_state)
      IDLE:    if (w_any) w_next = RUN;
      RUN:     if (w_last) w_next = DONE_S;
      DONE_S:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_ptr   <= '0;
      r_w     <= '0;
      r_gnt   <= '0;
      r_done  <= '0;
      r_sum   <= '0;
      r_busy  <= 1'b0;
      r_start <= 1'b0;
      r_add_a <= '0;
      r_add_b <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          r_done <= '0;
          if (w_any) begin
            r_add_a <= A_IN[w_idx*SIZE +: SIZE];
            r_add_b <= B_IN[w_idx*SIZE +: SIZE];
            r_gnt   <= w_onehot;
            r_w     <= w_idx;
            r_cnt   <= '0;
            r_start <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        RUN: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_sum   <= ADD_SUM;
            r_done  <= r_gnt;
            r_start <= 1'b0;
          end
        end
        DONE_S: begin
          r_done <= '0;
          r_gnt  <= '0;
          r_busy <= 1'b0;
          r_ptr  <= (r_w == IDX_W'(NREQ - 1)) ? '0 : r_w + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign GNT       = r_gnt;
  assign DONE      = r_done;
  assign SUM_OUT   = r_sum;
  assign BUSY      = r_busy;
  assign ADD_START = r_start;
  assign ADD_A     = r_add_a;
  assign ADD_B     = r_add_b;

endmodule
